// File: rtl/decode_scoreboard_pkg.sv
// Shared types and helpers for the decode-stage hazard/forwarding scoreboard.
package decode_scoreboard_pkg;

    // Forward-select code meaning "take the register file value".
    localparam int unsigned FWD_RF = 0;

    // Per-entry control flags; the destination address is kept alongside
    // in a separate array so its width can follow the AW parameter.
    typedef struct packed {
        logic valid;
        logic we;
        logic is_load;
    } sb_flags_t;

    // Width of a forward select: codes 0..DEPTH.
    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode <-> scoreboard bundle: issue request, operands, stage results, hazard answers.
interface decode_scoreboard_if #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int NSRC  = 2,
    parameter int SELW  = 3
) ();
    logic                 dec_valid;
    logic                 dec_we;
    logic [AW-1:0]        dec_waddr;
    logic                 dec_is_load;
    logic [NSRC*AW-1:0]   src_addr;
    logic [NSRC-1:0]      src_used;
    logic [NSRC*DW-1:0]   src_rf_data;
    logic [DEPTH*DW-1:0]  stage_result;
    logic                 hold;
    logic                 flush;
    logic                 stall;
    logic [NSRC*SELW-1:0] fwd_sel;
    logic [NSRC*DW-1:0]   fwd_data;
    logic [31:0]          stall_count;

    // Decode stage side.
    modport master (
        output dec_valid, dec_we, dec_waddr, dec_is_load,
        output src_addr, src_used, src_rf_data, stage_result, hold, flush,
        input  stall, fwd_sel, fwd_data, stall_count
    );

    // Scoreboard side.
    modport slave (
        input  dec_valid, dec_we, dec_waddr, dec_is_load,
        input  src_addr, src_used, src_rf_data, stage_result, hold, flush,
        output stall, fwd_sel, fwd_data, stall_count
    );
endinterface

// File: rtl/decode_scoreboard_sb_src_resolve.sv
// Per-operand resolver: youngest matching producer, its readiness, select and data.
module sb_src_resolve
    import decode_scoreboard_pkg::*;
#(
    parameter int AW               = 5,
    parameter int DW               = 32,
    parameter int DEPTH            = 4,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SELW             = sel_width(DEPTH)
) (
    input  logic [AW-1:0]       i_src_addr,
    input  logic [DW-1:0]       i_rf_data,
    input  logic [DEPTH-1:0]    i_valid,
    input  logic [DEPTH-1:0]    i_we,
    input  logic [DEPTH-1:0]    i_is_load,
    input  logic [DEPTH*AW-1:0] i_waddr,
    input  logic [DEPTH*DW-1:0] i_stage_result,
    output logic                o_hit,
    output logic                o_ready,
    output logic [SELW-1:0]     o_sel,
    output logic [DW-1:0]       o_data
);

    int w_win;

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        o_hit   = 1'b0;
        o_ready = 1'b1;
        o_sel   = SELW'(FWD_RF);
        o_data  = i_rf_data;
        w_win   = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_valid[k] && i_we[k] && (i_src_addr != '0) &&
                (i_waddr[k*AW +: AW] == i_src_addr)) begin
                o_hit = 1'b1;
                w_win = k;
            end
        end
        if (o_hit) begin
            o_ready = !i_is_load[w_win] || (w_win >= LOAD_READY_STAGE);
            o_sel   = SELW'(w_win + 1);
            o_data  = i_stage_result[w_win*DW +: DW];
        end
    end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode-stage scoreboard: shift register of in-flight writers, stall and stall counter.
module decode_scoreboard
    import decode_scoreboard_pkg::*;
#(
    parameter int AW               = 5,
    parameter int DW               = 32,
    parameter int DEPTH            = 4,
    parameter int NSRC             = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SELW             = sel_width(DEPTH)
) (
    input logic                clk,
    input logic                rst_n,
    decode_scoreboard_if.slave sb_if
);

    sb_flags_t             r_flags [DEPTH];
    logic [AW-1:0]         r_waddr [DEPTH];
    logic [31:0]           r_stall_count;

    logic [DEPTH-1:0]      w_valid;
    logic [DEPTH-1:0]      w_we;
    logic [DEPTH-1:0]      w_is_load;
    logic [DEPTH*AW-1:0]   w_waddr_flat;
    logic [NSRC-1:0]       w_hit;
    logic [NSRC-1:0]       w_ready;
    logic [NSRC*SELW-1:0]  w_sel_flat;
    logic [NSRC*DW-1:0]    w_data_flat;
    logic                  w_stall;
    logic                  w_issue;

    // Flatten the entry array into vectors the resolvers can scan.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_valid[k]               = r_flags[k].valid;
            w_we[k]                  = r_flags[k].we;
            w_is_load[k]             = r_flags[k].is_load;
            w_waddr_flat[k*AW +: AW] = r_waddr[k];
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        sb_src_resolve #(
            .AW               (AW),
            .DW               (DW),
            .DEPTH            (DEPTH),
            .LOAD_READY_STAGE (LOAD_READY_STAGE),
            .SELW             (SELW)
        ) u_resolve (
            .i_src_addr     (sb_if.src_addr[s*AW +: AW]),
            .i_rf_data      (sb_if.src_rf_data[s*DW +: DW]),
            .i_valid        (w_valid),
            .i_we           (w_we),
            .i_is_load      (w_is_load),
            .i_waddr        (w_waddr_flat),
            .i_stage_result (sb_if.stage_result),
            .o_hit          (w_hit[s]),
            .o_ready        (w_ready[s]),
            .o_sel          (w_sel_flat[s*SELW +: SELW]),
            .o_data         (w_data_flat[s*DW +: DW])
        );
    end

    // Stall when any used operand's youngest producer cannot forward yet; flush cancels it.
    always_comb begin
        w_stall = sb_if.dec_valid && !sb_if.flush &&
                  |(sb_if.src_used & w_hit & ~w_ready);
        w_issue = sb_if.dec_valid && !w_stall && !sb_if.flush;
    end

    assign sb_if.stall       = w_stall;
    assign sb_if.fwd_sel     = w_sel_flat;
    assign sb_if.fwd_data    = w_data_flat;
    assign sb_if.stall_count = r_stall_count;

    // Advance the writer pipeline unless downstream holds; decode enters as writer or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are a handful of flops, not a RAM, so every entry is reset
            // and the scoreboard is empty the moment rst_n falls.
            for (int k = 0; k < DEPTH; k++) begin
                r_flags[k] <= '0;
                r_waddr[k] <= '0;
            end
        end else if (!sb_if.hold) begin
            // NOTE: non-blocking assignments make every entry read its neighbour's
            // old value, so the loop order does not matter.
            r_flags[0] <= w_issue ? sb_flags_t'{valid: 1'b1, we: sb_if.dec_we,
                                                is_load: sb_if.dec_is_load}
                                  : sb_flags_t'('0);
            r_waddr[0] <= sb_if.dec_waddr;
            for (int k = 1; k < DEPTH; k++) begin
                r_flags[k] <= r_flags[k-1];
                r_waddr[k] <= r_waddr[k-1];
            end
        end
    end

    // Count stalled issue cycles that actually cost a clock, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && !sb_if.hold && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard: forwarding, load-use, priority, hold/flush, reset, saturation.
module tb_decode_scoreboard;
    import decode_scoreboard_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NSRC  = 2;
    localparam int LRS   = 2;
    localparam int SELW  = 3;

    localparam logic [DW-1:0] RF0 = 32'h1000_0001;
    localparam logic [DW-1:0] RF1 = 32'h2000_0002;
    localparam logic [DEPTH*DW-1:0] SR_DEFAULT =
        {32'h0000_00DD, 32'h0000_00CC, 32'h0000_00BB, 32'h0000_00AA};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    decode_scoreboard_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .NSRC(NSRC), .SELW(SELW)) bus ();

    decode_scoreboard #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .NSRC(NSRC),
        .LOAD_READY_STAGE(LRS), .SELW(SELW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SELW-1:0] sel(input int s);
        return bus.fwd_sel[s*SELW +: SELW];
    endfunction

    function automatic logic [DW-1:0] data(input int s);
        return bus.fwd_data[s*DW +: DW];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic we, input logic [AW-1:0] wa, input logic ld);
        bus.dec_valid   = v;
        bus.dec_we      = we;
        bus.dec_waddr   = wa;
        bus.dec_is_load = ld;
    endtask

    task automatic src(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] used);
        bus.src_addr = {a1, a0};
        bus.src_used = used;
    endtask

    task automatic drain();
        dec(1'b0, 1'b0, '0, 1'b0);
        src('0, '0, 2'b00);
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        repeat (DEPTH) cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        dec(1'b0, 1'b0, '0, 1'b0);
        src(5'd3, 5'd9, 2'b11);
        bus.src_rf_data  = {RF1, RF0};
        bus.stage_result = SR_DEFAULT;
        bus.hold         = 1'b0;
        bus.flush        = 1'b0;

        // Reset state
        #3;
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_sel0", 64'(sel(0)), 64'd0);
        check("rst_sel1", 64'(sel(1)), 64'd0);
        check("rst_data", 64'(bus.fwd_data), {RF1, RF0});
        check("rst_count", 64'(bus.stall_count), 64'd0);
        rst_n = 1'b1;

        // Back-to-back ALU dependency on r3
        dec(1'b1, 1'b1, 5'd3, 1'b0);
        src('0, '0, 2'b00);
        cyc();
        dec(1'b1, 1'b0, '0, 1'b0);
        src(5'd3, 5'd9, 2'b11);
        #1;
        check("alu_stall", 64'(bus.stall), 64'd0);
        check("alu_sel0", 64'(sel(0)), 64'd1);
        check("alu_data0", 64'(data(0)), 64'h0000_00AA);
        check("alu_sel1", 64'(sel(1)), 64'd0);
        check("alu_data1", 64'(data(1)), 64'(RF1));
        cyc();
        drain();

        // Load-use on r5: two stall cycles, then forward from entry 2
        dec(1'b1, 1'b1, 5'd5, 1'b1);
        cyc();
        dec(1'b1, 1'b1, 5'd6, 1'b0);
        src(5'd5, '0, 2'b01);
        #1;
        check("lu_stall_a", 64'(bus.stall), 64'd1);
        check("lu_sel_a", 64'(sel(0)), 64'd1);
        cyc();
        check("lu_stall_b", 64'(bus.stall), 64'd1);
        check("lu_sel_b", 64'(sel(0)), 64'd2);
        cyc();
        check("lu_stall_c", 64'(bus.stall), 64'd0);
        check("lu_sel_c", 64'(sel(0)), 64'd3);
        check("lu_data_c", 64'(data(0)), 64'h0000_00CC);
        check("lu_count", 64'(bus.stall_count), 64'd2);
        cyc();
        drain();

        // Youngest wins on r7; r0 never matches even with r0 writers in flight
        dec(1'b1, 1'b1, 5'd7, 1'b0);
        cyc();
        dec(1'b1, 1'b1, 5'd0, 1'b0);
        cyc();
        dec(1'b1, 1'b1, 5'd7, 1'b0);
        cyc();
        bus.stage_result = {32'h0000_00DD, 32'h0000_0011, 32'h0000_00BB, 32'h0000_0022};
        dec(1'b1, 1'b0, '0, 1'b0);
        src(5'd7, 5'd0, 2'b11);
        #1;
        check("yw_sel0", 64'(sel(0)), 64'd1);
        check("yw_data0", 64'(data(0)), 64'h0000_0022);
        check("r0_sel1", 64'(sel(1)), 64'd0);
        check("r0_data1", 64'(data(1)), 64'(RF1));
        cyc();
        check("yw_sel0_shift", 64'(sel(0)), 64'd2);
        bus.stage_result = SR_DEFAULT;
        drain();

        // Younger ALU writer shadows an older unready load to the same register
        dec(1'b1, 1'b1, 5'd8, 1'b1);
        cyc();
        dec(1'b1, 1'b1, 5'd8, 1'b0);
        cyc();
        dec(1'b1, 1'b0, '0, 1'b0);
        src(5'd8, '0, 2'b01);
        #1;
        check("shadow_stall", 64'(bus.stall), 64'd0);
        check("shadow_sel0", 64'(sel(0)), 64'd1);
        drain();

        // Unused source matching an unready load never stalls
        dec(1'b1, 1'b1, 5'd9, 1'b1);
        cyc();
        dec(1'b1, 1'b0, '0, 1'b0);
        src(5'd1, 5'd9, 2'b01);
        #1;
        check("unused_stall", 64'(bus.stall), 64'd0);
        check("unused_sel1", 64'(sel(1)), 64'd1);
        check("unused_count", 64'(bus.stall_count), 64'd2);
        cyc();
        drain();

        // Hold freezes a pending load and the counter
        dec(1'b1, 1'b1, 5'd5, 1'b1);
        cyc();
        dec(1'b1, 1'b1, 5'd6, 1'b0);
        src(5'd5, '0, 2'b01);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_stall", 64'(bus.stall), 64'd1);
            check("hold_sel0", 64'(sel(0)), 64'd1);
            check("hold_count", 64'(bus.stall_count), 64'd2);
            cyc();
        end
        bus.hold = 1'b0;
        #1;
        check("unhold_sel0", 64'(sel(0)), 64'd1);
        cyc();
        check("unhold_sel1", 64'(sel(0)), 64'd2);
        check("unhold_count_a", 64'(bus.stall_count), 64'd3);
        cyc();
        check("unhold_stall", 64'(bus.stall), 64'd0);
        check("unhold_count_b", 64'(bus.stall_count), 64'd4);
        cyc();
        drain();

        // Flush forces stall low and pushes a bubble, not the r5 writer
        dec(1'b1, 1'b1, 5'd5, 1'b1);
        cyc();
        dec(1'b1, 1'b1, 5'd5, 1'b0);
        src(5'd5, '0, 2'b01);
        bus.flush = 1'b1;
        #1;
        check("flush_stall", 64'(bus.stall), 64'd0);
        cyc();
        bus.flush = 1'b0;
        #1;
        check("flush_bubble_sel", 64'(sel(0)), 64'd2);
        check("flush_bubble_stall", 64'(bus.stall), 64'd1);
        check("flush_count", 64'(bus.stall_count), 64'd4);

        // Asynchronous reset in the middle of a stall
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_stall", 64'(bus.stall), 64'd0);
        check("arst_sel0", 64'(sel(0)), 64'd0);
        check("arst_sel1", 64'(sel(1)), 64'd0);
        check("arst_count", 64'(bus.stall_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        // Saturation: preload the counter just below all-ones
        @(negedge clk);
        force dut.r_stall_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_count;
        #1;
        check("sat_preload", 64'(bus.stall_count), 64'hFFFF_FFFE);
        dec(1'b1, 1'b1, 5'd5, 1'b1);
        src('0, '0, 2'b00);
        cyc();
        dec(1'b1, 1'b1, 5'd6, 1'b0);
        src(5'd5, '0, 2'b01);
        cyc();
        check("sat_count_a", 64'(bus.stall_count), 64'hFFFF_FFFF);
        cyc();
        check("sat_count_b", 64'(bus.stall_count), 64'hFFFF_FFFF);
        check("sat_stall", 64'(bus.stall), 64'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
- Parametrised hazard/forwarding unit for the decode stage; replaces the fixed two-stage (EX/MEM) compare logic.
- Tracks in-flight register writers across DEPTH post-decode stages in a shift-register scoreboard.
- Per source operand, selects the youngest matching producer's result, or the register file.
- Raises stall when the youngest producer's data is not yet available (load-use, multi-cycle results); keeps a saturating stall-cycle counter.

Parameters:
- AW, 5, register address width; address 0 is hardwired zero and never matches.
- DW, 32, data width.
- DEPTH, 4, number of tracked stages after decode; entry 0 = EX.
- NSRC, 2, number of source operands checked per instruction.
- LOAD_READY_STAGE, 2, lowest entry index at which a load's data is forwardable.
- SELW, $clog2(DEPTH+1), forward-select width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode holds a real instruction
- dec_we  in  1  decode instruction writes a register
- dec_waddr  in  AW  its destination register
- dec_is_load  in  1  its result comes from memory
- src_addr  in  NSRC*AW  source register addresses
- src_used  in  NSRC  source actually read; unused sources never stall
- src_rf_data  in  NSRC*DW  register-file read data
- stage_result  in  DEPTH*DW  current result held by each tracked stage
- hold  in  1  downstream stall; freezes the scoreboard
- flush  in  1  squash the decode instruction
- stall  out  1  decode must not issue this cycle
- fwd_sel  out  NSRC*SELW  0 = register file; k+1 = entry k
- fwd_data  out  NSRC*DW  resolved operand value
- stall_count  out  32  saturating count of stall cycles

Behaviour:
- Entry fields: valid, we, waddr, is_load. Reset clears all entries; stall_count = 0.
- Reset outputs follow from the cleared scoreboard: stall=0, fwd_sel=0, fwd_data=src_rf_data.
- Match, per source s and entry k: valid & we & waddr==src_addr[s] & src_addr[s]!=0.
- Priority: the lowest-index (youngest) matching entry wins; older matches are ignored.
- Ready: a winning entry is ready iff !is_load or k >= LOAD_READY_STAGE.
- fwd_sel / fwd_data (combinational):
  - winner exists: fwd_sel = k+1, fwd_data = stage_result[k];
  - no winner: fwd_sel = 0, fwd_data = src_rf_data.
- stall (combinational) = dec_valid & !flush & OR over s of (src_used[s] & winner exists & !ready).
- Sequential update each clock, with issue = dec_valid & !stall & !flush:
  - hold=1: all entries keep their values; nothing pushed.
  - hold=0: entry k+1 <= entry k; entry DEPTH-1 is dropped; entry 0 <= issue ? {1, dec_we, dec_waddr, dec_is_load} : bubble (valid=0).
- flush=1 with hold=0: a bubble enters entry 0; older entries still shift.
- flush overrides stall: stall=0 whenever flush=1.
- Simultaneous hold and flush: hold wins for the scoreboard; flush only forces stall low.
- stall_count increments on every cycle with stall=1 & hold=0; saturates at 0xFFFFFFFF.
- Latency: a writer issued in cycle t is visible in entry 0 at t+1 and at entry k at t+1+k (with no hold). It leaves the scoreboard after entry DEPTH-1; the register file must hold its value by then.
- Reset asserted mid-stream clears all entries immediately (asynchronous); stall drops in the same cycle.

Decomposition:
- Shared package: scoreboard entry struct, SELW function, FWD_RF = 0 constant.
- Sub-module: sb_src_resolve (one instance per source). Pure combinational priority match, ready, select and data mux.
- The top level holds the entry shift register, stall OR-reduction and counter.

Test Plan:
- Back-to-back ALU dependency: issue add r3 (non-load), then a source reading r3 in the next cycle -> stall=0, fwd_sel=1, fwd_data=stage_result[0]=0x0000_00AA.
- Load-use, LOAD_READY_STAGE=2: lw r5, then a reader of r5 -> stall=1 for 2 cycles; third cycle stall=0, fwd_sel=3; stall_count=2.
- Youngest wins: writers to r7 at entries 2 (0x11) and 0 (0x22) -> fwd_sel=1, fwd_data=0x22. Reading r0 with writers to r0 -> fwd_sel=0, data from the register file.
- Unused source: src_used=2'b01, src 1 matches a not-ready load -> stall=0.
- Hold/flush: pending load with hold=1 for 3 cycles -> entries frozen, stall_count unchanged. flush=1 with a dependency -> stall=0 and entry 0 becomes a bubble.
- Async reset during stall: drop rst_n mid-cycle -> stall=0 immediately, all fwd_sel=0, stall_count=0. Saturation: preload the count near max -> stays at 0xFFFFFFFF.
